wb_queue: RTL and testbench



---
 rtl/wb_queue_if.sv | 29 ++
 rtl/wb_queue.sv | 116 +++++++++++
 tb/tb_wb_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// wb_queue_if: EX-to-register-file write-back bus.
//   ex_wr_*  : EX result write request (valid/ready, rd, data)
//   reg_wr_* : head entry toward the register file write port, plus stall
// Modports:
//   master : EX / register-file side (drives requests and stall)
//   slave  : the write-back queue
interface wb_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          ex_wr_valid_i;
  logic          ex_wr_ready_o;
  logic [AW-1:0] ex_wr_rd_i;
  logic [DW-1:0] ex_wr_data_i;
  logic          reg_wr_valid_o;
  logic [AW-1:0] reg_wr_rd_o;
  logic [DW-1:0] reg_wr_data_o;
  logic          reg_wr_stall_i;

  modport master (
    output ex_wr_valid_i, ex_wr_rd_i, ex_wr_data_i, reg_wr_stall_i,
    input  ex_wr_ready_o, reg_wr_valid_o, reg_wr_rd_o, reg_wr_data_o
  );

  modport slave (
    input  ex_wr_valid_i, ex_wr_rd_i, ex_wr_data_i, reg_wr_stall_i,
    output ex_wr_ready_o, reg_wr_valid_o, reg_wr_rd_o, reg_wr_data_o
  );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back buffer between EX and the register file.
//   Accepts (rd, data) writes from EX, holds up to DEPTH entries, drains the
//   oldest entry one per cycle unless the register file stalls.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   bus (slave)       ex_wr_* request side, reg_wr_* drain side + stall
//   rs1/rs2_addr_i    ID read indices
//   rs1/rs2_hit_o     a pending entry matches the index
//   rs1/rs2_fwd_data_o data of the youngest matching pending entry
//   count_o           entries held
// Configuration:
//   WB_BYPASS_EN      when defined, build the pending-entry forwarding
//                     compare; otherwise hits and forward data are tied 0.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_queue_if.slave     bus,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_hit_o,
  output logic [DW-1:0] rs1_fwd_data_o,
  output logic          rs2_hit_o,
  output logic [DW-1:0] rs2_fwd_data_o,
  output logic [AW:0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic ready, head_vld, enq, pop;

  // Readiness depends only on the registered count: a full queue refuses
  // a write even in a cycle where the head is draining.
  assign ready    = count < (AW+1)'(DEPTH);
  assign head_vld = count != '0;
  // A write to r0 completes the handshake but is dropped.
  assign enq      = bus.ex_wr_valid_i && ready && (bus.ex_wr_rd_i != '0);
  assign pop      = head_vld && !bus.reg_wr_stall_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is defined by the count window.
  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      rd_mem[wr_ptr]   <= bus.ex_wr_rd_i;
      data_mem[wr_ptr] <= bus.ex_wr_data_i;
    end
  end

  assign bus.ex_wr_ready_o  = ready;
  assign bus.reg_wr_valid_o = head_vld;
  assign bus.reg_wr_rd_o    = head_vld ? rd_mem[rd_ptr]   : '0;
  assign bus.reg_wr_data_o  = head_vld ? data_mem[rd_ptr] : '0;
  assign count_o            = count;

`ifdef WB_BYPASS_EN
  logic [1:0][AW-1:0] rs_addr;
  logic [1:0]         rs_hit;
  logic [1:0][DW-1:0] rs_data;

  assign rs_addr = {rs2_addr_i, rs1_addr_i};

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    // Walk entries oldest to youngest; the last match wins, so the
    // youngest pending value is forwarded. The head still counts even
    // when it pops this cycle.
    always_comb begin
      logic [PW-1:0] idx;
      rs_hit[p]  = 1'b0;
      rs_data[p] = '0;
      idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if (((AW+1)'(k) < count) && (rs_addr[p] != '0) &&
            (rd_mem[idx] == rs_addr[p])) begin
          rs_hit[p]  = 1'b1;
          rs_data[p] = data_mem[idx];
        end
      end
    end
  end

  assign rs1_hit_o      = rs_hit[0];
  assign rs1_fwd_data_o = rs_data[0];
  assign rs2_hit_o      = rs_hit[1];
  assign rs2_fwd_data_o = rs_data[1];
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_addr_i, rs2_addr_i};
  assign rs1_hit_o      = 1'b0;
  assign rs1_fwd_data_o = '0;
  assign rs2_hit_o      = 1'b0;
  assign rs2_fwd_data_o = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed + random stimulus for wb_queue, checked every cycle
// against a queue-based reference model of the write-back buffer.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_queue_if #(.AW(AW), .DW(DW)) bus ();

  logic [AW-1:0] rs1, rs2;
  logic          h1, h2;
  logic [DW-1:0] f1, f2;
  logic [AW:0]   cnt;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .rs1_addr_i    (rs1),
    .rs2_addr_i    (rs2),
    .rs1_hit_o     (h1),
    .rs1_fwd_data_o(f1),
    .rs2_hit_o     (h2),
    .rs2_fwd_data_o(f2),
    .count_o       (cnt)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending entry with matching nonzero rd.
  task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    if (a != '0)
      foreach (q[i])
        if (q[i].rd == a) begin
          hit = 1'b1;
          d   = q[i].data;
        end
`endif
  endtask

  // One clock cycle: drive, check outputs against the model, advance model.
  task automatic cyc(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                     input logic st, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic          eh1, eh2;
    logic [DW-1:0] ed1, ed2;
    int            sz;
    bus.ex_wr_valid_i  = v;
    bus.ex_wr_rd_i     = rd;
    bus.ex_wr_data_i   = d;
    bus.reg_wr_stall_i = st;
    rs1 = a1;
    rs2 = a2;
    #3;
    sz = q.size();
    chk("count", 64'(cnt), 64'(sz));
    chk("ready", 64'(bus.ex_wr_ready_o), 64'(sz < DEPTH));
    chk("valid", 64'(bus.reg_wr_valid_o), 64'(sz > 0));
    chk("head_rd", 64'(bus.reg_wr_rd_o), sz > 0 ? 64'(q[0].rd) : 64'd0);
    chk("head_data", 64'(bus.reg_wr_data_o), sz > 0 ? 64'(q[0].data) : 64'd0);
    model_fwd(a1, eh1, ed1);
    model_fwd(a2, eh2, ed2);
    chk("rs1_hit", 64'(h1), 64'(eh1));
    chk("rs1_fwd", 64'(f1), 64'(ed1));
    chk("rs2_hit", 64'(h2), 64'(eh2));
    chk("rs2_fwd", 64'(f2), 64'(ed2));
    if (!rst_n) q.delete();
    else begin
      if (sz > 0 && !st) void'(q.pop_front());
      if (v && sz < DEPTH && rd != '0) q.push_back('{rd: rd, data: d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ex_wr_valid_i  = 1'b0;
    bus.ex_wr_rd_i     = '0;
    bus.ex_wr_data_i   = '0;
    bus.reg_wr_stall_i = 1'b0;
    rs1 = '0;
    rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single write, next cycle on the register port, then popped.
    cyc(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0);
    idle(2);

    // 2: fill under stall, fifth write held off, then drain in order.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, AW'(i + 1), DW'(32'h100 + i), 1'b1, AW'(i + 1), 5'd2);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b0, 5'd4, 5'd1);

    // 3: write to r0 is accepted but never stored.
    cyc(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
    idle(2);

    // 4: two writes to r5 under stall, forward the younger one.
    cyc(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 5'd0);
    cyc(1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 5'd0);
    cyc(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
    idle(3);

    // 5: reset with three pending entries discards them all.
    for (int i = 0; i < 3; i++) cyc(1'b1, AW'(i + 7), DW'(i + 32'hC0), 1'b1, 5'd7, 5'd8);
    rst_n = 1'b0;
    cyc(1'b0, '0, '0, 1'b1, 5'd7, '0);
    rst_n = 1'b1;
    idle(3);
    // enqueue + pop together at count 2 keeps the count.
    cyc(1'b1, 5'd9,  32'hD0, 1'b1, '0, '0);
    cyc(1'b1, 5'd10, 32'hD1, 1'b1, '0, '0);
    cyc(1'b1, 5'd11, 32'hD2, 1'b0, 5'd10, 5'd11);
    cyc(1'b0, '0, '0, 1'b1, 5'd10, 5'd11);
    idle(4);

    // Random traffic with small rd range for collisions and r0 writes.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      cyc(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), DW'($urandom),
          ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    rst_n = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
